// File: rtl/intpol2_d4_div_by_sub_pkg.sv
// rtl/intpol2_d4_div_by_sub_pkg.sv - shared state encoding and counter sizing for the divider
package intpol2_d4_div_by_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Iteration counter must be able to represent 0..W
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/intpol2_d4_div_by_sub_sub_stage.sv
// rtl/intpol2_d4_div_by_sub_sub_stage.sv - one restoring shift/compare/subtract step
module intpol2_d4_sub_stage #(
    parameter int W = 34
) (
    input  logic [W:0]   rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W:0]   rem_out,
    output logic         q_bit
);

    logic [W+1:0] trial;
    logic [W:0]   diff;

    // Partial remainder is kept one bit wider than the operand so the
    // trial value never wraps, even for an all-ones dividend.
    always_comb begin
        trial   = {rem_in, bit_in};
        diff    = trial[W:0] - {1'b0, divisor};
        q_bit   = (trial >= {2'b00, divisor});
        rem_out = q_bit ? diff : trial[W:0];
    end

endmodule

// File: rtl/intpol2_d4_div_by_sub.sv
// rtl/intpol2_d4_div_by_sub.sv - iterative restoring divider, one quotient bit per cycle
module intpol2_d4_div_by_sub
    import intpol2_d4_div_by_sub_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_bits     = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         clear,
    input  logic                         start,
    input  logic [DATA_WIDTH+N_bits-1:0] dividend,
    input  logic [DATA_WIDTH+N_bits-1:0] divisor,
    output logic                         busy,
    output logic                         done,
    output logic [DATA_WIDTH+N_bits-1:0] quotient,
    output logic [DATA_WIDTH+N_bits-1:0] remainder,
    output logic                         div_by_zero
);

    localparam int W     = DATA_WIDTH + N_bits;
    localparam int CNT_W = cnt_width(W);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W:0]       rem_q, rem_d;
    logic [W-1:0]     dvd_q, dvd_d;
    logic [W-1:0]     dsr_q, dsr_d;
    logic [W-1:0]     quot_q, quot_d;
    logic [W-1:0]     rmd_q, rmd_d;
    logic             dbz_q, dbz_d;

    logic [W:0]       step_rem;
    logic             step_bit;

    intpol2_d4_sub_stage #(
        .W (W)
    ) u_sub_stage (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[W-1]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quot_d  = quot_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_BUSY;
                    cnt_d   = '0;
                    rem_d   = '0;
                    dvd_d   = dividend;
                    dsr_d   = divisor;
                end
            end
            ST_BUSY: begin
                // Dividend register doubles as the quotient shift register
                rem_d = step_rem;
                dvd_d = {dvd_q[W-2:0], step_bit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W - 1)) begin
                    state_d = ST_DONE;
                    quot_d  = {dvd_q[W-2:0], step_bit};
                    rmd_d   = step_rem[W-1:0];
                    dbz_d   = (dsr_q == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quot_q  <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            quot_q  <= quot_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == ST_BUSY);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quot_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/intpol2_d4_div_by_sub.md
INTPOL2_D4_DIV_BY_SUB -- requirements
Module: intpol2_D4_div_by_sub

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, fractional/data part width.
REQ-002 SHALL have parameter N_bits, default 2, integer-part width; W = DATA_WIDTH+N_bits is the operand width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rstn, input, 1, reset; synchronous and active-low.
REQ-005 SHALL have port clear, input, 1, synchronous active-high soft clear.
REQ-006 SHALL have port start, input, 1, request a division.
REQ-007 SHALL have port dividend, input, W, unsigned dividend.
REQ-008 SHALL have port divisor, input, W, unsigned divisor.
REQ-009 SHALL have port busy, output, 1, high while iterating.
REQ-010 SHALL have port done, output, 1, one-cycle result-valid pulse.
REQ-011 SHALL have port quotient, output, W, floor(dividend/divisor).
REQ-012 SHALL have port remainder, output, W, dividend mod divisor.
REQ-013 SHALL have port div_by_zero, output, 1, set with done when divisor was 0.

Function
REQ-014 SHALL implement restoring shift-compare-subtract division, one quotient bit per cycle, MSB first.
REQ-015 SHALL use states IDLE, BUSY, DONE; IDLE->BUSY on start, BUSY->DONE after W iterations, DONE->IDLE (or BUSY if start) next cycle.
REQ-016 SHALL accept start only when busy is low (IDLE or DONE); start during BUSY is ignored.
REQ-017 SHALL register dividend and divisor at the accepting edge; later input changes have no effect on the running operation.
REQ-018 SHALL assert busy from the cycle after acceptance for exactly W cycles.
REQ-019 SHALL assert done for exactly one cycle, W+1 cycles after the accepting edge.
REQ-020 SHALL update quotient, remainder and div_by_zero only at the edge that enters DONE and hold them until the next result.
REQ-021 SHALL keep the partial remainder W+1 bits wide, so no compare/subtract overflows at dividend = 2^W-1.
REQ-022 SHALL, when divisor = 0, keep the same latency and return quotient all-ones, remainder = dividend, div_by_zero = 1.
REQ-023 SHALL, when start coincides with done, begin the new operation and keep the old outputs until its own DONE.
REQ-024 SHALL, on clear high, abort any operation and force the reset state at that edge; clear has priority over start.

Reset
REQ-025 SHALL, on rstn low at a rising edge, set state IDLE and set busy, done, div_by_zero, quotient, remainder and the iteration counter to 0.
REQ-026 SHALL abandon a division in progress on reset mid-operation without producing done.
REQ-027 SHALL accept start on the first edge with rstn high.

Structure
REQ-028 SHALL take the state encodings IDLE/BUSY/DONE from the shared intpol2_D4 package header.
REQ-029 SHALL take the iteration-counter width, $clog2(W+1), from the same package header.
REQ-030 SHALL place the compare/subtract step in a combinational sub-module intpol2_D4_sub_stage (inputs: partial remainder, divisor; outputs: next remainder, quotient bit).

Verification (default parameters, W = 34)
REQ-031 SHALL check: start, dividend 100, divisor 7 -> done 35 cycles later, quotient 14, remainder 2, div_by_zero 0.
REQ-032 SHALL check: dividend 2^34-1, divisor 1 -> quotient 2^34-1, remainder 0; dividend 5, divisor 9 -> quotient 0, remainder 5.
REQ-033 SHALL check: divisor 0, dividend 123 -> quotient all-ones, remainder 123, div_by_zero 1, same 35-cycle latency.
REQ-034 SHALL check: second start with 50/5 pulsed mid-BUSY -> ignored; first result (100/7) unchanged.
REQ-035 SHALL check: start 40/3 in the done cycle -> done again 35 cycles later with quotient 13, remainder 1.
REQ-036 SHALL check: clear or rstn low at iteration 10 -> busy 0 next cycle, all outputs 0, no done, fresh start works.
